avalon_ram_slave: RTL and testbench

//  Avalon-MM responder (slave) word RAM with programmable wait states; it is the far end of the CPU bus master.

---
 rtl/avalon_ram_slave_if.sv | 21 ++
 rtl/avalon_ram_slave.sv | 110 +++++++++++
 tb/tb_avalon_ram_slave.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/avalon_ram_slave_if.sv
// Avalon-MM bus bundle between a CPU bus master and the word-RAM responder.
interface avalon_ram_slave_if;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        error;

    modport master (
        output address, write, read, writedata, byteenable,
        input  waitrequest, readdata, error
    );

    modport slave (
        input  address, write, read, writedata, byteenable,
        output waitrequest, readdata, error
    );
endinterface

// File: rtl/avalon_ram_slave.sv
// Avalon-MM responder word RAM with programmable wait states, byte-enable
// writes, range/alignment decode and a sticky protocol-error flag.
module avalon_ram_slave #(
  parameter logic [31:0] BASE_ADDR     = 32'hBFC00000,
  parameter int unsigned DEPTH_LOG2    = 10,
  parameter int unsigned WAIT_CYCLES   = 2,
  parameter string       RAM_INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               reset,
  avalon_ram_slave_if.slave  bus
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [3:0] CNT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        error_q, error_d;

  logic [29:0]           word_off;
  logic                  hit;
  logic [DEPTH_LOG2-1:0] index;
  logic                  req;
  logic                  cmpl;
  logic                  wait_req;
  logic                  we;

  always_comb begin
    word_off = bus.address[31:2] - BASE_ADDR[31:2];
    hit      = (bus.address[1:0] == 2'b00) && (bus.address >= BASE_ADDR)
               && ((word_off >> DEPTH_LOG2) == '0);
    index    = word_off[DEPTH_LOG2-1:0];
    req      = bus.read | bus.write;
  end

  // The completion cycle is folded into S_WAIT with cnt_q==0 (or S_IDLE when
  // WAIT_CYCLES==0); the bus-visible timing is unchanged.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    error_d  = error_q;
    cmpl     = 1'b0;
    wait_req = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            cmpl = 1'b1;
          end else begin
            wait_req = 1'b1;
            cnt_d    = CNT_LOAD;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          wait_req = 1'b1;
          error_d  = 1'b1;
          state_d  = S_IDLE;
        end else if (cnt_q == '0) begin
          cmpl    = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_req = 1'b1;
          cnt_d    = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (cmpl && (!hit || (bus.read && bus.write))) error_d = 1'b1;
    // Reset holds the bus stalled and blocks any commit at an edge inside reset.
    if (!reset) begin
      wait_req = 1'b1;
      cmpl     = 1'b0;
    end
  end

  always_comb begin
    we = cmpl && bus.write && !bus.read && hit;
    bus.readdata    = (cmpl && bus.read && !bus.write && hit) ? mem[index] : '0;
    bus.waitrequest = wait_req;
    bus.error       = error_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.byteenable[b]) mem[index][8*b +: 8] <= bus.writedata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Bench for avalon_ram_slave: vector table, multi-cycle corner sequences and
// randomized transfers against a word-array reference model.
module tb_avalon_ram_slave;

    localparam longint BASE  = 64'hBFC00000;
    localparam int     WORDS = 1024;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    avalon_ram_slave_if b2();
    avalon_ram_slave_if b0();

    avalon_ram_slave #(.BASE_ADDR(32'hBFC00000), .DEPTH_LOG2(10), .WAIT_CYCLES(2))
        dut2 (.clk(clk), .reset(reset), .bus(b2));
    avalon_ram_slave #(.BASE_ADDR(32'hBFC00000), .DEPTH_LOG2(10), .WAIT_CYCLES(0))
        dut0 (.clk(clk), .reset(reset), .bus(b0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] mdl [WORDS];
    logic        mdl_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic ref_hit(input logic [31:0] a);
        longint ua = longint'(a);
        return (ua % 4 == 0) && (ua >= BASE) && (ua < BASE + 4 * WORDS);
    endfunction

    // Called at posedge+1; returns at posedge+1 after the completion edge.
    task automatic xfer(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] rdata, output int cyc, output logic err);
        logic done;
        b2.read = rd; b2.write = wr; b2.address = a; b2.writedata = d; b2.byteenable = be;
        cyc = 0; rdata = '0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            cyc++;
            if (!b2.waitrequest) begin
                rdata = b2.readdata;
                done  = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL xfer_timeout: got no completion want completion within 40 cycles");
        end
        @(posedge clk); #1;
        err = b2.error;
        b2.read = 1'b0; b2.write = 1'b0;
    endtask

    initial begin
        logic [31:0] rdata, exp_rd, a, d;
        logic [3:0]  be;
        logic        err, rd, wr, h;
        int          cyc, idx;

        reset = 1'b1;
        b2.read = 1'b0; b2.write = 1'b0; b2.address = '0; b2.writedata = '0; b2.byteenable = '0;
        b0.read = 1'b0; b0.write = 1'b0; b0.address = '0; b0.writedata = '0; b0.byteenable = '0;
        #3 reset = 1'b0;
        #20;
        chk("rst_waitreq2", 32'(b2.waitrequest), 32'd1);
        chk("rst_readdata2", b2.readdata, 32'h0);
        chk("rst_error2", 32'(b2.error), 32'd0);
        chk("rst_waitreq0", 32'(b0.waitrequest), 32'd1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_waitreq2", 32'(b2.waitrequest), 32'd0);
        chk("idle_readdata2", b2.readdata, 32'h0);

        tbl.push_back('{1'b0, 1'b1, 32'hBFC00004, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'hBFC00004, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'hBFC00008, 32'h11223344, 4'hF, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'hBFC00008, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'hBFC00008, 32'h0,        4'h0, 32'h11BB33DD, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'hBFC00008, 32'h55555555, 4'h0, 32'h0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'hBFC00008, 32'h0,        4'hF, 32'h11BB33DD, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'hBFC00FFC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'hBFC00FFC, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'hBFC01000, 32'h0,        4'hF, 32'h0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 32'hBFC00002, 32'h0,        4'hF, 32'h0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 32'h00000000, 32'h0,        4'hF, 32'h0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 32'hBFC00004, 32'h0,        4'hF, 32'h0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 32'hBFC00004, 32'h0,        4'hF, 32'hDEADBEEF, 1'b1});

        for (int i = 0; i < tbl.size(); i++) begin
            xfer(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].be, rdata, cyc, err);
            chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rd);
            chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'd3);
            chk($sformatf("vec%0d_error", i), 32'(err), 32'(tbl[i].exp_err));
        end

        // Zero wait states: four writes then four back-to-back reads, one per cycle.
        for (int i = 0; i < 4; i++) begin
            b0.write = 1'b1; b0.byteenable = 4'hF;
            b0.address = 32'hBFC00010 + 32'(4 * i);
            b0.writedata = 32'hA5A50000 + 32'(i * 17);
            @(negedge clk);
            chk($sformatf("ws0_wr%0d_waitreq", i), 32'(b0.waitrequest), 32'd0);
            @(posedge clk); #1;
        end
        b0.write = 1'b0; b0.read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b0.address = 32'hBFC00010 + 32'(4 * i);
            @(negedge clk);
            chk($sformatf("ws0_rd%0d_waitreq", i), 32'(b0.waitrequest), 32'd0);
            chk($sformatf("ws0_rd%0d_data", i), b0.readdata, 32'hA5A50000 + 32'(i * 17));
            @(posedge clk); #1;
        end
        b0.read = 1'b0;
        chk("ws0_error", 32'(b0.error), 32'd0);

        // Reset pulled while a write sits in its wait states.
        b2.write = 1'b1; b2.read = 1'b0; b2.address = 32'hBFC00004;
        b2.writedata = 32'h12345678; b2.byteenable = 4'hF;
        @(negedge clk);
        chk("rstmid_waitreq_t0", 32'(b2.waitrequest), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rstmid_waitreq_in_reset", 32'(b2.waitrequest), 32'd1);
        b2.write = 1'b0;
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_error_after", 32'(b2.error), 32'd0);
        chk("rstmid_waitreq_idle", 32'(b2.waitrequest), 32'd0);
        xfer(1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'hF, rdata, cyc, err);
        chk("rstmid_word_kept", rdata, 32'hDEADBEEF);
        chk("rstmid_cycles", 32'(cyc), 32'd3);

        // Read dropped after one wait cycle.
        b2.read = 1'b1; b2.address = 32'hBFC00004;
        @(negedge clk);
        chk("drop_waitreq_t0", 32'(b2.waitrequest), 32'd1);
        @(posedge clk); #1;
        b2.read = 1'b0;
        @(posedge clk); #1;
        chk("drop_error", 32'(b2.error), 32'd1);
        chk("drop_waitreq_idle", 32'(b2.waitrequest), 32'd0);
        xfer(1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'hF, rdata, cyc, err);
        chk("drop_next_rdata", rdata, 32'hDEADBEEF);
        chk("drop_next_cycles", 32'(cyc), 32'd3);
        mdl_err = err;

        // Random traffic over the first 16 words plus assorted misses.
        for (int i = 0; i < 16; i++) begin
            mdl[i] = $urandom;
            xfer(1'b0, 1'b1, 32'(BASE + 4 * i), mdl[i], 4'hF, rdata, cyc, err);
        end
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) < 8) begin
                a = 32'(BASE + 4 * $urandom_range(0, 15));
            end else begin
                case ($urandom_range(0, 3))
                    0: a = 32'(BASE - 4);
                    1: a = 32'(BASE + 4 * WORDS);
                    2: a = 32'(BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3));
                    default: a = $urandom & 32'h7FFFFFFC;
                endcase
            end
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin rd = 1'b1; wr = 1'b0; end
                5, 6, 7, 8:    begin rd = 1'b0; wr = 1'b1; end
                default:       begin rd = 1'b1; wr = 1'b1; end
            endcase
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            h  = ref_hit(a);
            idx = int'((longint'(a) - BASE) / 4);
            exp_rd = (h && rd && !wr) ? mdl[idx] : 32'h0;
            if (h && wr && !rd) begin
                for (int b = 0; b < 4; b++) if (be[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
            end
            if (!h || (rd && wr)) mdl_err = 1'b1;
            xfer(rd, wr, a, d, be, rdata, cyc, err);
            chk($sformatf("rnd%0d_rdata a=%h", n, a), rdata, exp_rd);
            chk($sformatf("rnd%0d_cycles", n), 32'(cyc), 32'd3);
            chk($sformatf("rnd%0d_error", n), 32'(err), 32'(mdl_err));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
